// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : grf_wb_arbiter
//  Function : Shares the single GRF write port between W-stage writeback
//             (fixed priority) and a buffered long-latency result FIFO.
//             Tracks in-flight long-latency destinations in a pending
//             scoreboard and raises stall_req when the FIFO head starves.
//  Revision : 1.0 - initial release
// ============================================================================
module grf_wb_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        w_we,
   input  logic [4:0]  w_a3,
   input  logic [31:0] w_wd,
   input  logic [31:0] w_pc,
   input  logic        m_valid,
   output logic        m_ready,
   input  logic [4:0]  m_a3,
   input  logic [31:0] m_wd,
   input  logic [31:0] m_pc,
   input  logic        iss_valid,
   input  logic [4:0]  iss_a3,
   output logic        iss_ready,
   input  logic [4:0]  q_a1,
   input  logic [4:0]  q_a2,
   output logic        q1_busy,
   output logic        q2_busy,
   output logic        stall_req,
   output logic        grf_we,
   output logic [4:0]  grf_a3,
   output logic [31:0] grf_wd,
   output logic [31:0] grf_wpc
);

   localparam int                c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                c_CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [c_PTR_W:0]  c_DEPTH    = (c_PTR_W + 1)'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(MAX_WAIT);

   // FIFO storage and control
   logic [4:0]          r_a3_mem [DEPTH];
   logic [31:0]         r_wd_mem [DEPTH];
   logic [31:0]         r_pc_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_PTR_W:0]    r_count;
   logic [31:0]         r_pending;
   logic [c_CNT_W-1:0]  r_wait;

   logic        w_empty;
   logic        w_full;
   logic        w_wsel;
   logic        w_pop;
   logic        w_push;
   logic        w_iss_set;
   logic [4:0]  w_head_a3;
   logic [31:0] w_set_mask;
   logic [31:0] w_clr_mask;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_DEPTH);
   assign w_head_a3 = r_a3_mem[r_rd_ptr];

   // W-stage owns the port only for a real (non-$0) write; otherwise the
   // FIFO head takes it and is popped at the edge.
   assign w_wsel    = w_we && (w_a3 != 5'd0);
   assign w_pop     = !w_wsel && !w_empty;

   // Results for $0 complete the handshake but are dropped here.
   assign m_ready   = !w_full && !reset;
   assign w_push    = m_valid && m_ready && (m_a3 != 5'd0);

   assign iss_ready = !r_pending[iss_a3];
   assign w_iss_set = iss_valid && iss_ready && (iss_a3 != 5'd0);
   assign w_set_mask = w_iss_set ? (32'd1 << iss_a3) : 32'd0;
   assign w_clr_mask = w_pop ? (32'd1 << w_head_a3) : 32'd0;

   // Bit 0 is never set, so $0 always reads idle.
   assign q1_busy   = r_pending[q_a1];
   assign q2_busy   = r_pending[q_a2];

   assign stall_req = !reset && !w_empty && (r_wait >= c_WAIT_MAX);

   // Write-port mux; everything forced low while reset is held.
   always_comb begin
      grf_we  = 1'b0;
      grf_a3  = 5'd0;
      grf_wd  = 32'd0;
      grf_wpc = 32'd0;
      if (!reset) begin
         if (w_wsel) begin
            grf_we  = 1'b1;
            grf_a3  = w_a3;
            grf_wd  = w_wd;
            grf_wpc = w_pc;
         end else if (!w_empty) begin
            grf_we  = 1'b1;
            grf_a3  = w_head_a3;
            grf_wd  = r_wd_mem[r_rd_ptr];
            grf_wpc = r_pc_mem[r_rd_ptr];
         end
      end
   end

   // FIFO payload storage; contents are meaningless once count is cleared.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_a3_mem[r_wr_ptr] <= m_a3;
         r_wd_mem[r_wr_ptr] <= m_wd;
         r_pc_mem[r_wr_ptr] <= m_pc;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + (c_PTR_W + 1)'(1);
         else if (!w_push && w_pop) r_count <= r_count - (c_PTR_W + 1)'(1);
      end
   end

   // Pending scoreboard: clear on head writeback, set on issue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_pending <= 32'd0;
      else       r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
   end

   // Starvation counter: counts blocked head cycles, saturating at MAX_WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           r_wait <= '0;
      else if (w_empty || w_pop)           r_wait <= '0;
      else if (w_wsel && r_wait < c_WAIT_MAX) r_wait <= r_wait + c_CNT_W'(1);
   end

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grf_wb_arbiter
//  Function : Self-checking bench for grf_wb_arbiter: directed scenarios
//             followed by randomized traffic against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grf_wb_arbiter;

   localparam int DEPTH    = 2;
   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_we;
   logic [4:0]  w_a3;
   logic [31:0] w_wd, w_pc;
   logic        m_valid, m_ready;
   logic [4:0]  m_a3;
   logic [31:0] m_wd, m_pc;
   logic        iss_valid, iss_ready;
   logic [4:0]  iss_a3, q_a1, q_a2;
   logic        q1_busy, q2_busy, stall_req;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd, grf_wpc;

   always #5 clk = ~clk;

   grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) u_dut (
      .clk(clk), .reset(reset),
      .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
      .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
      .iss_valid(iss_valid), .iss_a3(iss_a3), .iss_ready(iss_ready),
      .q_a1(q_a1), .q_a2(q_a2), .q1_busy(q1_busy), .q2_busy(q2_busy),
      .stall_req(stall_req),
      .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_wpc(grf_wpc)
   );

   // Reference model: result queue, pending set, starvation counter
   typedef struct {
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   bit          mpend[32];
   int          mwait;
   logic [4:0]  infl[$];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit mdl_stall();
      return (mq.size() > 0) && (mwait >= MAX_WAIT);
   endfunction

   task automatic mdl_clear();
      mq.delete();
      infl.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      mwait = 0;
   endtask

   task automatic idle();
      w_we = 0; w_a3 = 0; w_wd = 0; w_pc = 0;
      m_valid = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
      iss_valid = 0; iss_a3 = 0; q_a1 = 0; q_a2 = 0;
   endtask

   task automatic compare_all();
      bit          e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd, e_pc;
      e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
      if (w_we && w_a3 != 0) begin
         e_we = 1; e_a3 = w_a3; e_wd = w_wd; e_pc = w_pc;
      end else if (mq.size() > 0) begin
         e_we = 1; e_a3 = mq[0].a3; e_wd = mq[0].wd; e_pc = mq[0].pc;
      end
      chk("grf_we", grf_we, e_we);
      chk("grf_a3", grf_a3, e_a3);
      chk("grf_wd", grf_wd, e_wd);
      chk("grf_wpc", grf_wpc, e_pc);
      chk("m_ready", m_ready, mq.size() < DEPTH);
      chk("stall_req", stall_req, mdl_stall());
      chk("iss_ready", iss_ready, (iss_a3 == 0) || !mpend[iss_a3]);
      chk("q1_busy", q1_busy, (q_a1 != 0) && mpend[q_a1]);
      chk("q2_busy", q2_busy, (q_a2 != 0) && mpend[q_a2]);
   endtask

   // Apply one clock edge to both DUT and model, return at the next negedge.
   task automatic advance();
      bit   wsel, pop, nonempty, ready, iss_ok, push;
      ent_t h, n;
      wsel     = w_we && (w_a3 != 0);
      nonempty = mq.size() > 0;
      pop      = !wsel && nonempty;
      ready    = mq.size() < DEPTH;
      push     = m_valid && ready && (m_a3 != 0);
      iss_ok   = iss_valid && (iss_a3 != 0) && !mpend[iss_a3];
      n.a3 = m_a3; n.wd = m_wd; n.pc = m_pc;
      @(posedge clk);
      if (pop) begin
         h = mq.pop_front();
         mpend[h.a3] = 1'b0;
      end
      if (push) begin
         mq.push_back(n);
         if (infl.size() > 0 && infl[0] == n.a3) void'(infl.pop_front());
      end
      if (iss_ok) begin
         mpend[iss_a3] = 1'b1;
         infl.push_back(iss_a3);
      end
      if (!nonempty || pop)            mwait = 0;
      else if (wsel && mwait < MAX_WAIT) mwait++;
      @(negedge clk);
   endtask

   task automatic cycle();
      #1;
      compare_all();
      advance();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_we"}, grf_we, 0);
      chk({tag, "_a3"}, grf_a3, 0);
      chk({tag, "_wd"}, grf_wd, 0);
      chk({tag, "_wpc"}, grf_wpc, 0);
      chk({tag, "_stall"}, stall_req, 0);
      chk({tag, "_q1"}, q1_busy, 0);
      chk({tag, "_q2"}, q2_busy, 0);
      chk({tag, "_mrdy"}, m_ready, 0);
   endtask

   int pct;

   initial begin
      idle();
      mdl_clear();
      reset = 1;
      w_we = 1; w_a3 = 5; w_wd = 32'h55; q_a1 = 3;
      #2;
      chk_reset_outputs("rst0");
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      idle();

      // W-only write
      w_we = 1; w_a3 = 5; w_wd = 32'h1234; w_pc = 32'h3000;
      #1;
      chk("wonly_we", grf_we, 1);
      chk("wonly_a3", grf_a3, 5);
      chk("wonly_wd", grf_wd, 32'h1234);
      chk("wonly_pc", grf_wpc, 32'h3000);
      chk("wonly_mrdy", m_ready, 1);
      cycle();

      // Scoreboard round trip
      idle(); iss_valid = 1; iss_a3 = 8;
      cycle();
      q_a1 = 8; iss_valid = 1; iss_a3 = 8;
      #1;
      chk("sb_busy", q1_busy, 1);
      chk("sb_reissue", iss_ready, 0);
      cycle();
      idle(); m_valid = 1; m_a3 = 8; m_wd = 32'hAA; m_pc = 32'h4000; q_a1 = 8;
      cycle();
      idle(); q_a1 = 8;
      #1;
      chk("sb_wr_we", grf_we, 1);
      chk("sb_wr_a3", grf_a3, 8);
      chk("sb_wr_wd", grf_wd, 32'hAA);
      cycle();
      #1;
      chk("sb_cleared", q1_busy, 0);
      cycle();

      // Collision: W wins, head follows
      idle(); w_we = 1; w_a3 = 2; w_wd = 32'h22; m_valid = 1; m_a3 = 9; m_wd = 32'h99;
      cycle();
      idle(); w_we = 1; w_a3 = 3; w_wd = 32'h33;
      #1;
      chk("coll_w_a3", grf_a3, 3);
      cycle();
      idle();
      #1;
      chk("coll_m_a3", grf_a3, 9);
      chk("coll_m_wd", grf_wd, 32'h99);
      cycle();
      #1;
      chk("coll_empty", grf_we, 0);
      cycle();

      // Full FIFO, back-pressure, starvation stall
      idle(); w_we = 1; w_a3 = 4; m_valid = 1; m_a3 = 10; m_wd = 32'hA0;
      cycle();
      m_a3 = 11; m_wd = 32'hB0;
      cycle();
      m_valid = 0;
      #1;
      chk("full_mrdy", m_ready, 0);
      for (int i = 0; i < 3; i++) cycle();
      w_we = 0;
      #1;
      chk("stall_up", stall_req, 1);
      chk("drain1_a3", grf_a3, 10);
      cycle();
      #1;
      chk("stall_down", stall_req, 0);
      chk("drain2_a3", grf_a3, 11);
      cycle();

      // $0 handling
      idle(); w_we = 1; w_a3 = 0; w_wd = 32'hDEAD;
      #1;
      chk("z_w_empty", grf_we, 0);
      cycle();
      idle(); m_valid = 1; m_a3 = 12; m_wd = 32'hC0;
      cycle();
      idle(); w_we = 1; w_a3 = 0;
      #1;
      chk("z_w_drain_a3", grf_a3, 12);
      cycle();
      idle(); m_valid = 1; m_a3 = 0;
      #1;
      chk("z_m_rdy", m_ready, 1);
      cycle();
      idle();
      #1;
      chk("z_m_nowr", grf_we, 0);
      cycle();
      iss_valid = 1; iss_a3 = 0; q_a1 = 0;
      cycle();
      #1;
      chk("z_iss_busy", q1_busy, 0);
      chk("z_iss_rdy", iss_ready, 1);
      cycle();

      // Async reset mid-operation
      idle(); iss_valid = 1; iss_a3 = 8;
      cycle();
      idle(); w_we = 1; w_a3 = 1; m_valid = 1; m_a3 = 13;
      cycle();
      m_a3 = 14;
      cycle();
      idle(); w_we = 1; w_a3 = 6; w_wd = 32'h66; q_a1 = 8; q_a2 = 13;
      #2;
      reset = 1;
      #1;
      chk_reset_outputs("arst");
      @(posedge clk);
      @(negedge clk);
      reset = 0;
      mdl_clear();
      idle(); q_a1 = 8;
      #1;
      chk("arst_q1", q1_busy, 0);
      chk("arst_nowr", grf_we, 0);
      cycle();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         pct = ((c / 200) % 2 == 0) ? 50 : 90;
         w_we = ($urandom_range(0, 99) < pct) && (!mdl_stall() || $urandom_range(0, 99) < 2);
         w_a3 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         w_wd = $urandom; w_pc = $urandom;
         iss_valid = $urandom_range(0, 99) < 25;
         iss_a3 = 5'($urandom_range(0, 31));
         q_a1 = 5'($urandom_range(0, 31));
         q_a2 = (infl.size() > 0 && $urandom_range(0, 1) == 1) ? infl[0] : 5'($urandom_range(0, 31));
         m_wd = $urandom; m_pc = $urandom;
         if (infl.size() > 0 && $urandom_range(0, 99) < 50) begin
            m_valid = 1; m_a3 = infl[0];
         end else if ($urandom_range(0, 99) < 5) begin
            m_valid = 1; m_a3 = 0;
         end else begin
            m_valid = 0; m_a3 = 5'($urandom_range(0, 31));
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
